// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of transparent D latches: round-robin arbitration of two
// requesters, then a registered one-hot enable pulse framed by setup and hold windows.
module latch_bank_write_ctrl #(
  parameter int WIDTH        = 4,
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             busy,
  output logic             last_grant,
  output logic             addr_err
);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  localparam int MAX_SE  = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_CYC = (MAX_SE > HOLD_CYCLES) ? MAX_SE : HOLD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Each window counts down from N-1 to 0, so a window lasts exactly N cycles.
  localparam logic [CW-1:0] SETUP_LOAD = CW'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] EN_LOAD    = CW'((EN_CYCLES > 0) ? EN_CYCLES - 1 : 0);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] en_mask;

  logic             grant_vld;
  logic             grant_idx;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic [DEPTH-1:0] sel_mask;
  logic             xfer;

  // Out-of-range addresses decode to an all-zero mask, which doubles as the error flag.
  function automatic logic [DEPTH-1:0] decode(input logic [AW-1:0] a);
    decode = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == AW'(i)) decode[i] = 1'b1;
    end
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_idx = ~last_grant;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant_idx = 1'b0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_idx = 1'b1;
    end
  end

  assign sel_addr   = grant_idx ? req1_addr : req0_addr;
  assign sel_data   = grant_idx ? req1_data : req0_data;
  assign sel_mask   = decode(sel_addr);
  assign xfer       = (state == IDLE) && grant_vld;

  // rst_n gates the readies so no requester sees an acceptance while reset is held.
  assign req0_ready = rst_n && xfer && !grant_idx;
  assign req1_ready = rst_n && xfer &&  grant_idx;

  // NOTE: all state here uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      en_mask    <= '0;
      lat_en     <= '0;
      lat_d      <= '0;
      busy       <= 1'b0;
      addr_err   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      addr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            lat_d      <= sel_data;
            en_mask    <= sel_mask;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            addr_err   <= ~|sel_mask;
            if (SETUP_CYCLES > 0) begin
              state <= SETUP;
              cnt   <= SETUP_LOAD;
            end else begin
              state  <= ENABLE;
              cnt    <= EN_LOAD;
              lat_en <= sel_mask;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= ENABLE;
            cnt    <= EN_LOAD;
            lat_en <= en_mask;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            lat_en <= '0;
            if (HOLD_CYCLES > 0) begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          lat_en <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // A zero-length enable window would never open the latch.
  a_en_cycles_legal: assert property (@(posedge clk) EN_CYCLES >= 1);

  a_lat_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lat_en));

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Self-checking bench for latch_bank_write_ctrl: a cycle-phase scoreboard for the default
// configuration plus directed runs on zero-window and DEPTH=3 instances.
module tb_latch_bank_write_ctrl;

  localparam int S   = 1;
  localparam int E   = 2;
  localparam int H   = 1;
  localparam int TOT = S + E + H;

  typedef struct packed {
    logic       who;
    logic [1:0] addr;
    logic [3:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  // default instance
  logic       d0_valid, d1_valid, d0_ready, d1_ready;
  logic [1:0] d0_addr, d1_addr;
  logic [3:0] d0_data, d1_data, d_lat_d, d_lat_en;
  logic       d_busy, d_last_grant, d_addr_err;

  // zero-window instance
  logic       z0_valid, z1_valid, z0_ready, z1_ready;
  logic [1:0] z0_addr, z1_addr;
  logic [3:0] z0_data, z1_data, z_lat_d, z_lat_en;
  logic       z_busy, z_last_grant, z_addr_err;

  // DEPTH=3 instance
  logic       o0_valid, o1_valid, o0_ready, o1_ready;
  logic [1:0] o0_addr, o1_addr;
  logic [3:0] o0_data, o1_data, o_lat_d;
  logic [2:0] o_lat_en;
  logic       o_busy, o_last_grant, o_addr_err;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard model of the default instance
  int         m_phase = 0;
  logic       m_last  = 1'b1;
  logic [1:0] m_addr  = '0;
  logic [3:0] m_data  = '0;
  wr_t        sb[$];
  int         grant_log[$];
  logic       p_busy  = 1'b0;
  logic [3:0] p_lat_d = '0;

  latch_bank_write_ctrl #(.WIDTH(4), .DEPTH(4), .SETUP_CYCLES(S), .EN_CYCLES(E), .HOLD_CYCLES(H)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(d0_valid), .req0_addr(d0_addr), .req0_data(d0_data), .req0_ready(d0_ready),
    .req1_valid(d1_valid), .req1_addr(d1_addr), .req1_data(d1_data), .req1_ready(d1_ready),
    .lat_d(d_lat_d), .lat_en(d_lat_en), .busy(d_busy), .last_grant(d_last_grant), .addr_err(d_addr_err)
  );

  latch_bank_write_ctrl #(.WIDTH(4), .DEPTH(4), .SETUP_CYCLES(0), .EN_CYCLES(1), .HOLD_CYCLES(0)) u_zw (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(z0_valid), .req0_addr(z0_addr), .req0_data(z0_data), .req0_ready(z0_ready),
    .req1_valid(z1_valid), .req1_addr(z1_addr), .req1_data(z1_data), .req1_ready(z1_ready),
    .lat_d(z_lat_d), .lat_en(z_lat_en), .busy(z_busy), .last_grant(z_last_grant), .addr_err(z_addr_err)
  );

  latch_bank_write_ctrl #(.WIDTH(4), .DEPTH(3), .SETUP_CYCLES(1), .EN_CYCLES(2), .HOLD_CYCLES(1)) u_oor (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(o0_valid), .req0_addr(o0_addr), .req0_data(o0_data), .req0_ready(o0_ready),
    .req1_valid(o1_valid), .req1_addr(o1_addr), .req1_data(o1_data), .req1_ready(o1_ready),
    .lat_d(o_lat_d), .lat_en(o_lat_en), .busy(o_busy), .last_grant(o_last_grant), .addr_err(o_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
    m_addr  = '0;
    m_data  = '0;
    sb.delete();
    p_busy  = 1'b0;
    p_lat_d = '0;
  endtask

  // Called at posedge+1 with inputs already driven for this cycle; samples at the
  // negedge, then advances the model over the coming posedge.
  task automatic step();
    logic       g;
    logic       any;
    logic [3:0] exp_en;
    wr_t        w;
    @(negedge clk);
    if (m_phase == 1) begin
      check("sb_size", 32'(sb.size()), 32'(1));
      if (sb.size() > 0) begin
        w      = sb.pop_front();
        m_addr = w.addr;
        m_data = w.data;
      end
    end
    any    = d0_valid || d1_valid;
    g      = (d0_valid && d1_valid) ? ~m_last : d1_valid;
    exp_en = (m_phase > S && m_phase <= S + E) ? (4'b0001 << m_addr) : 4'b0000;
    check("ready0", 32'(d0_ready), 32'(m_phase == 0 && any && !g));
    check("ready1", 32'(d1_ready), 32'(m_phase == 0 && any && g));
    check("one_ready", 32'(d0_ready & d1_ready), 32'(0));
    check("busy", 32'(d_busy), 32'(m_phase != 0));
    check("lat_en", 32'(d_lat_en), 32'(exp_en));
    check("lat_d", 32'(d_lat_d), 32'(m_data));
    check("last_grant", 32'(d_last_grant), 32'(m_last));
    check("addr_err", 32'(d_addr_err), 32'(0));
    check("lat_en_onehot0", 32'($onehot0(d_lat_en)), 32'(1));
    if (p_busy) check("lat_d_stable", 32'(d_lat_d), 32'(p_lat_d));
    if (d0_ready && d0_valid) grant_log.push_back(0);
    if (d1_ready && d1_valid) grant_log.push_back(1);
    p_busy  = d_busy;
    p_lat_d = d_lat_d;
    if (m_phase == 0) begin
      if (any) begin
        w.who  = g;
        w.addr = g ? d1_addr : d0_addr;
        w.data = g ? d1_data : d0_data;
        sb.push_back(w);
        m_last  = g;
        m_phase = 1;
      end
    end else begin
      m_phase = (m_phase == TOT) ? 0 : m_phase + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    repeat (TOT + 2) step();
  endtask

  initial begin
    wr_t        zq[$];
    wr_t        w;
    logic [3:0] z_exp_d;
    logic [3:0] zp_en;
    logic [3:0] zp_d;
    logic [1:0] oa[2];
    logic [3:0] od[2];

    rst_n    = 1'b0;
    d0_valid = 1'b1; d0_addr = '0; d0_data = '0;
    d1_valid = 1'b1; d1_addr = '0; d1_data = '0;
    z0_valid = 1'b1; z0_addr = '0; z0_data = '0;
    z1_valid = 1'b0; z1_addr = '0; z1_data = '0;
    o0_valid = 1'b1; o0_addr = '0; o0_data = '0;
    o1_valid = 1'b0; o1_addr = '0; o1_data = '0;

    // reset values, with requests already pending
    #12;
    check("rst_ready0", 32'(d0_ready), 32'(0));
    check("rst_ready1", 32'(d1_ready), 32'(0));
    check("rst_lat_en", 32'(d_lat_en), 32'(0));
    check("rst_lat_d", 32'(d_lat_d), 32'(0));
    check("rst_busy", 32'(d_busy), 32'(0));
    check("rst_addr_err", 32'(d_addr_err), 32'(0));
    check("rst_last_grant", 32'(d_last_grant), 32'(1));
    check("rst_z_ready0", 32'(z0_ready), 32'(0));
    check("rst_o_ready0", 32'(o0_ready), 32'(0));
    check("rst_o_lat_en", 32'(o_lat_en), 32'(0));
    z0_valid = 1'b0;
    o0_valid = 1'b0;
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // contention: both requesters valid for four full windows
    grant_log.delete();
    d0_valid = 1'b1; d0_addr = 2'd1;
    d1_valid = 1'b1; d1_addr = 2'd3;
    for (int i = 0; i < 4 * (TOT + 1); i++) begin
      d0_data = 4'(i);
      d1_data = 4'(15 - i);
      step();
    end
    check("contention_grants", 32'(grant_log.size()), 32'(4));
    for (int i = 0; i < grant_log.size(); i++) check($sformatf("grant_order%0d", i), 32'(grant_log[i]), 32'(i % 2));
    drain();

    // single write from requester 0, valid held so it is re-granted right after HOLD
    d0_valid = 1'b1; d0_addr = 2'd2; d0_data = 4'hA;
    repeat (TOT + 2) step();
    drain();

    // zero windows: back-to-back writes to entries 0..3
    z_exp_d = '0;
    zp_en   = '0;
    zp_d    = '0;
    for (int k = 0; k < 8; k++) begin
      z0_valid = 1'b1;
      z0_addr  = 2'(k / 2);
      z0_data  = 4'(5 + k / 2);
      @(negedge clk);
      if (k % 2 == 0) begin
        check("zw_ready", 32'(z0_ready), 32'(1));
        check("zw_lat_en_idle", 32'(z_lat_en), 32'(0));
        w.who  = 1'b0;
        w.addr = z0_addr;
        w.data = z0_data;
        zq.push_back(w);
      end else begin
        check("zw_ready_busy", 32'(z0_ready), 32'(0));
        w       = zq.pop_front();
        z_exp_d = w.data;
        check("zw_lat_en", 32'(z_lat_en), 32'(4'b0001 << w.addr));
      end
      check("zw_lat_d", 32'(z_lat_d), 32'(z_exp_d));
      if (zp_en != 0) check("zw_lat_d_stable", 32'(z_lat_d), 32'(zp_d));
      zp_en = z_lat_en;
      zp_d  = z_lat_d;
      @(posedge clk);
      #1;
    end
    z0_valid = 1'b0;

    // DEPTH=3: out-of-range entry 3, then in-range entry 2
    oa[0] = 2'd3; od[0] = 4'h6;
    oa[1] = 2'd2; od[1] = 4'h9;
    for (int n = 0; n < 2; n++) begin
      for (int t = 0; t <= TOT + 1; t++) begin
        o0_valid = (t == 0);
        o0_addr  = oa[n];
        o0_data  = od[n];
        @(negedge clk);
        check($sformatf("oor%0d_ready_t%0d", n, t), 32'(o0_ready), 32'(t == 0));
        check($sformatf("oor%0d_busy_t%0d", n, t), 32'(o_busy), 32'(t >= 1 && t <= TOT));
        check($sformatf("oor%0d_addr_err_t%0d", n, t), 32'(o_addr_err), 32'(t == 1 && oa[n] >= 3));
        check($sformatf("oor%0d_lat_en_t%0d", n, t), 32'(o_lat_en),
              32'((t > S && t <= S + E && oa[n] < 3) ? (3'b001 << oa[n]) : 3'b000));
        if (t >= 1) check($sformatf("oor%0d_lat_d_t%0d", n, t), 32'(o_lat_d), 32'(od[n]));
        @(posedge clk);
        #1;
      end
    end
    o0_valid = 1'b0;

    // randomized traffic from both requesters
    for (int i = 0; i < 10000; i++) begin
      d0_valid = 1'($urandom);
      d1_valid = 1'($urandom);
      d0_addr  = 2'($urandom);
      d1_addr  = 2'($urandom);
      d0_data  = 4'($urandom);
      d1_data  = 4'($urandom);
      step();
    end
    drain();

    // reset in the middle of the enable pulse
    d0_valid = 1'b1; d0_addr = 2'd1; d0_data = 4'h3;
    step();
    d0_valid = 1'b0;
    step();
    step();
    check("mid_lat_en_before", 32'(d_lat_en), 32'(4'b0010));
    d0_valid = 1'b1; d0_addr = 2'd0; d0_data = 4'hC;
    d1_valid = 1'b1; d1_addr = 2'd3; d1_data = 4'h7;
    rst_n = 1'b0;
    #1;
    check("mid_rst_lat_en", 32'(d_lat_en), 32'(0));
    check("mid_rst_busy", 32'(d_busy), 32'(0));
    check("mid_rst_ready0", 32'(d0_ready), 32'(0));
    check("mid_rst_ready1", 32'(d1_ready), 32'(0));
    check("mid_rst_last_grant", 32'(d_last_grant), 32'(1));
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    grant_log.delete();
    step();
    check("post_rst_first_grant_count", 32'(grant_log.size()), 32'(1));
    if (grant_log.size() > 0) check("post_rst_first_grant", 32'(grant_log[0]), 32'(0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
